// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU control path: FSM state encoding,
// decoded instruction classes and the class-precedence order.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_IF   = 3'd1,
    ST_ID   = 3'd2,
    ST_EX   = 3'd3,
    ST_MEM  = 3'd4,
    ST_WB   = 3'd5,
    ST_HALT = 3'd6,
    ST_ERR  = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CLS_NONE   = 3'd0,
    CLS_LOAD   = 3'd1,
    CLS_STORE  = 3'd2,
    CLS_ALUR   = 3'd3,
    CLS_ALUIMM = 3'd4,
    CLS_JUMP   = 3'd5,
    CLS_BRANCH = 3'd6
  } cls_t;

  // Bit positions inside the raw class vector; a higher index wins.
  localparam int CLS_VEC_W  = 6;
  localparam int CB_BRANCH  = 0;
  localparam int CB_JUMP    = 1;
  localparam int CB_ALUIMM  = 2;
  localparam int CB_ALUR    = 3;
  localparam int CB_STORE   = 4;
  localparam int CB_LOAD    = 5;

  function automatic cls_t pick_class(input logic [CLS_VEC_W-1:0] v);
    cls_t c;
    c = CLS_NONE;
    if (v[CB_LOAD])        c = CLS_LOAD;
    else if (v[CB_STORE])  c = CLS_STORE;
    else if (v[CB_ALUR])   c = CLS_ALUR;
    else if (v[CB_ALUIMM]) c = CLS_ALUIMM;
    else if (v[CB_JUMP])   c = CLS_JUMP;
    else if (v[CB_BRANCH]) c = CLS_BRANCH;
    return c;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on a memory request and flags the last
// allowed waiting cycle so the sequencer can give up on the next edge.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Asserted in the cycle whose increment would bring the count to MEM_TIMEOUT.
  assign expired_o = en_i && !clr_i && (cnt_q == LAST_WAIT);

endmodule

// File: rtl/mc_phase_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer: stage enables, memory handshake,
// register-file write strobe, PC update and retired-instruction count.
module mc_phase_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        halt_req,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        is_alur,
  input  logic        is_aluimm,
  input  logic        is_jump,
  input  logic        is_branch,
  input  logic        cond,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        if_en,
  output logic        id_en,
  output logic        ex_en,
  output logic        mem_en,
  output logic        wb_en,
  output logic        rf_we,
  output logic        pc_we,
  output logic        pc_sel_target,
  output logic        busy,
  output logic        halted,
  output logic        err_timeout,
  output logic [31:0] instr_cnt
);

  state_t state_q, state_d;
  cls_t   cls_q, cls_d;
  cls_t   cls_ex;

  logic if_en_q, if_en_d;
  logic id_en_q, id_en_d;
  logic ex_en_q, ex_en_d;
  logic mem_en_q, mem_en_d;
  logic wb_en_q, wb_en_d;
  logic rf_we_q, rf_we_d;
  logic mem_we_q, mem_we_d;
  logic pc_we_q, pc_we_d;
  logic pc_sel_q, pc_sel_d;
  logic busy_q, busy_d;
  logic halted_q, halted_d;
  logic err_q, err_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;

  logic in_wait;
  logic wait_clr;
  logic wait_en;
  logic wait_expired;
  logic boundary;

  assign in_wait  = (state_q == ST_IF) || (state_q == ST_MEM);
  assign wait_clr = !in_wait || mem_ack;
  assign wait_en  = in_wait && !mem_ack;

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_wait (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (wait_clr),
    .en_i      (wait_en),
    .expired_o (wait_expired)
  );

  assign cls_ex = pick_class({is_load, is_store, is_alur, is_aluimm, is_jump, is_branch});

  always_comb begin
    state_d  = state_q;
    cls_d    = cls_q;
    if_en_d  = 1'b0;
    mem_en_d = 1'b0;
    pc_sel_d = 1'b0;
    boundary = 1'b0;

    unique case (state_q)
      ST_IDLE: if (run) state_d = ST_IF;
      ST_IF: begin
        // An ack in the expiring cycle still completes the fetch.
        if (mem_ack) begin
          if_en_d = 1'b1;
          state_d = ST_ID;
        end else if (wait_expired) begin
          state_d = ST_ERR;
        end
      end
      ST_ID: state_d = ST_EX;
      ST_EX: begin
        cls_d = cls_ex;
        case (cls_ex)
          CLS_LOAD, CLS_STORE:  state_d = ST_MEM;
          CLS_ALUR, CLS_ALUIMM: state_d = ST_WB;
          CLS_JUMP: begin
            boundary = 1'b1;
            pc_sel_d = 1'b1;
          end
          CLS_BRANCH: begin
            boundary = 1'b1;
            pc_sel_d = cond;
          end
          default: boundary = 1'b1;
        endcase
      end
      ST_MEM: begin
        if (mem_ack) begin
          mem_en_d = 1'b1;
          if (cls_q == CLS_LOAD) state_d = ST_WB;
          else                   boundary = 1'b1;
        end else if (wait_expired) begin
          state_d = ST_ERR;
        end
      end
      ST_WB:   boundary = 1'b1;
      ST_HALT: if (run && !halt_req) state_d = ST_IF;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_IDLE;
    endcase

    if (boundary) state_d = halt_req ? ST_HALT : ST_IF;
  end

  // State-aligned outputs are decoded from the next state so they are
  // registered yet high exactly while the FSM sits in the matching state.
  always_comb begin
    pc_we_d     = boundary;
    id_en_d     = (state_d == ST_ID);
    ex_en_d     = (state_d == ST_EX);
    wb_en_d     = (state_d == ST_WB);
    rf_we_d     = (state_d == ST_WB);
    mem_we_d    = (state_d == ST_MEM) && (cls_d == CLS_STORE);
    busy_d      = !((state_d == ST_IDLE) || (state_d == ST_HALT) || (state_d == ST_ERR));
    halted_d    = (state_d == ST_HALT);
    err_d       = err_q || (state_d == ST_ERR);
    instr_cnt_d = instr_cnt_q + {31'd0, boundary};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cls_q       <= CLS_NONE;
      if_en_q     <= 1'b0;
      id_en_q     <= 1'b0;
      ex_en_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      wb_en_q     <= 1'b0;
      rf_we_q     <= 1'b0;
      mem_we_q    <= 1'b0;
      pc_we_q     <= 1'b0;
      pc_sel_q    <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
      err_q       <= 1'b0;
      instr_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cls_q       <= cls_d;
      if_en_q     <= if_en_d;
      id_en_q     <= id_en_d;
      ex_en_q     <= ex_en_d;
      mem_en_q    <= mem_en_d;
      wb_en_q     <= wb_en_d;
      rf_we_q     <= rf_we_d;
      mem_we_q    <= mem_we_d;
      pc_we_q     <= pc_we_d;
      pc_sel_q    <= pc_sel_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
      err_q       <= err_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  // mem_req is the only output decoded directly from the current state.
  assign mem_req       = in_wait;
  assign mem_we        = mem_we_q;
  assign if_en         = if_en_q;
  assign id_en         = id_en_q;
  assign ex_en         = ex_en_q;
  assign mem_en        = mem_en_q;
  assign wb_en         = wb_en_q;
  assign rf_we         = rf_we_q;
  assign pc_we         = pc_we_q;
  assign pc_sel_target = pc_sel_q;
  assign busy          = busy_q;
  assign halted        = halted_q;
  assign err_timeout   = err_q;
  assign instr_cnt     = instr_cnt_q;

endmodule

// File: tb/tb_mc_phase_ctrl.sv
// Directed bench for mc_phase_ctrl: per-cycle output vectors checked on the
// negative edge against hand-derived tables.
module tb_mc_phase_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0, halt_req = 1'b0, cond = 1'b0, mem_ack = 1'b0;
  logic is_load = 1'b0, is_store = 1'b0, is_alur = 1'b0;
  logic is_aluimm = 1'b0, is_jump = 1'b0, is_branch = 1'b0;

  logic mem_req, mem_we, if_en, id_en, ex_en, mem_en, wb_en, rf_we;
  logic pc_we, pc_sel_target, busy, halted, err_timeout;
  logic [31:0] instr_cnt;

  // {mem_req, mem_we, if_en, id_en, ex_en, mem_en, wb_en, rf_we, pc_we, pc_sel_target, busy, halted}
  logic [11:0] obs;

  int n_vec = 0;
  int n_err = 0;

  mc_phase_ctrl #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .run(run), .halt_req(halt_req),
    .is_load(is_load), .is_store(is_store), .is_alur(is_alur),
    .is_aluimm(is_aluimm), .is_jump(is_jump), .is_branch(is_branch),
    .cond(cond), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .if_en(if_en), .id_en(id_en),
    .ex_en(ex_en), .mem_en(mem_en), .wb_en(wb_en), .rf_we(rf_we),
    .pc_we(pc_we), .pc_sel_target(pc_sel_target), .busy(busy),
    .halted(halted), .err_timeout(err_timeout), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  assign obs = {mem_req, mem_we, if_en, id_en, ex_en, mem_en, wb_en, rf_we,
                pc_we, pc_sel_target, busy, halted};

  task automatic clear_inputs();
    run = 0; halt_req = 0; cond = 0; mem_ack = 0;
    is_load = 0; is_store = 0; is_alur = 0; is_aluimm = 0; is_jump = 0; is_branch = 0;
  endtask

  // Leaves the DUT in IDLE just after a negedge; the next posedge is cycle 1.
  task automatic start();
    @(negedge clk);
    rst = 1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1;
    clear_inputs();
    #1;
    n_vec++;
    if (obs !== 12'b0) begin
      n_err++; $display("FAIL reset_outputs: got %b expected %b", obs, 12'b0);
    end
    n_vec++;
    if (instr_cnt !== 32'd0) begin
      n_err++; $display("FAIL reset_instr_cnt: got %0d expected 0", instr_cnt);
    end
    run = 1; mem_ack = 1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({obs, err_timeout} !== 13'b0) begin
      n_err++; $display("FAIL reset_hold: got %b expected %b", {obs, err_timeout}, 13'b0);
    end
  endtask

  task automatic test_alu();
    logic [11:0] exp_t [5];
    exp_t = '{12'b1000_0000_0010, 12'b0011_0000_0010, 12'b0000_1000_0010,
              12'b0000_0011_0010, 12'b1000_0000_1010};
    start();
    run = 1; is_alur = 1; mem_ack = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_vec++;
      if (obs !== exp_t[k]) begin
        n_err++; $display("FAIL alu_c%0d: got %b expected %b", k + 1, obs, exp_t[k]);
      end
    end
    n_vec++;
    if (instr_cnt !== 32'd1) begin
      n_err++; $display("FAIL alu_instr_cnt: got %0d expected 1", instr_cnt);
    end
  endtask

  task automatic test_load();
    logic [11:0] exp_t [8];
    exp_t = '{12'b1000_0000_0010, 12'b0011_0000_0010, 12'b0000_1000_0010,
              12'b1000_0000_0010, 12'b1000_0000_0010, 12'b1000_0000_0010,
              12'b0000_0111_0010, 12'b1000_0000_1010};
    start();
    run = 1; is_load = 1; is_store = 1; mem_ack = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_vec++;
      if (obs !== exp_t[k]) begin
        n_err++; $display("FAIL load_c%0d: got %b expected %b", k + 1, obs, exp_t[k]);
      end
      if (k == 1) mem_ack = 0;
      if (k == 5) mem_ack = 1;
    end
  endtask

  task automatic test_store();
    logic [11:0] exp_t [5];
    exp_t = '{12'b1000_0000_0010, 12'b0011_0000_0010, 12'b0000_1000_0010,
              12'b1100_0000_0010, 12'b1000_0100_1010};
    start();
    run = 1; is_store = 1; is_alur = 1; mem_ack = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_vec++;
      if (obs !== exp_t[k]) begin
        n_err++; $display("FAIL store_c%0d: got %b expected %b", k + 1, obs, exp_t[k]);
      end
    end
  endtask

  task automatic test_branch();
    logic [11:0] exp_t [7];
    exp_t = '{12'b1000_0000_0010, 12'b0011_0000_0010, 12'b0000_1000_0010,
              12'b1000_0000_1110, 12'b0011_0000_0010, 12'b0000_1000_0010,
              12'b1000_0000_1010};
    start();
    run = 1; is_branch = 1; cond = 1; mem_ack = 1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      n_vec++;
      if (obs !== exp_t[k]) begin
        n_err++; $display("FAIL branch_c%0d: got %b expected %b", k + 1, obs, exp_t[k]);
      end
      if (k == 3) cond = 0;
    end
    n_vec++;
    if (instr_cnt !== 32'd2) begin
      n_err++; $display("FAIL branch_instr_cnt: got %0d expected 2", instr_cnt);
    end
  endtask

  // Jump outranks branch (taken with cond=0), then a no-class instruction.
  task automatic test_precedence_nop();
    logic [11:0] exp_t [7];
    exp_t = '{12'b1000_0000_0010, 12'b0011_0000_0010, 12'b0000_1000_0010,
              12'b1000_0000_1110, 12'b0011_0000_0010, 12'b0000_1000_0010,
              12'b1000_0000_1010};
    start();
    run = 1; is_jump = 1; is_branch = 1; cond = 0; mem_ack = 1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      n_vec++;
      if (obs !== exp_t[k]) begin
        n_err++; $display("FAIL prec_nop_c%0d: got %b expected %b", k + 1, obs, exp_t[k]);
      end
      if (k == 3) begin
        is_jump = 0; is_branch = 0;
      end
    end
  endtask

  task automatic test_timeout();
    start();
    run = 1; is_alur = 1; mem_ack = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      n_vec++;
      if (k < 16 && obs !== 12'b1000_0000_0010) begin
        n_err++; $display("FAIL tmo_wait_c%0d: got %b expected %b", k, obs, 12'b1000_0000_0010);
      end else if (k == 16 && {obs, err_timeout} !== 13'b0_0000_0000_0001) begin
        n_err++; $display("FAIL tmo_err_entry: got %b expected %b", {obs, err_timeout}, 13'b1);
      end
    end
    mem_ack = 1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({obs, err_timeout} !== 13'b0_0000_0000_0001) begin
      n_err++; $display("FAIL tmo_sticky: got %b expected %b", {obs, err_timeout}, 13'b1);
    end

    start();
    run = 1; is_alur = 1; mem_ack = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      n_vec++;
      if (obs !== 12'b1000_0000_0010) begin
        n_err++; $display("FAIL tmo_edge_c%0d: got %b expected %b", k, obs, 12'b1000_0000_0010);
      end
    end
    mem_ack = 1;
    @(negedge clk);
    n_vec++;
    if ({obs, err_timeout} !== 13'b0011_0000_0010_0) begin
      n_err++; $display("FAIL tmo_ack_wins: got %b expected %b", {obs, err_timeout}, 13'b0011_0000_0010_0);
    end
  endtask

  task automatic test_halt_reset();
    logic [11:0] exp_t [10];
    exp_t = '{12'b1000_0000_0010, 12'b0011_0000_0010, 12'b0000_1000_0010,
              12'b0000_0011_0010, 12'b0000_0000_1001, 12'b0000_0000_0001,
              12'b1000_0000_0010, 12'b0011_0000_0010, 12'b0000_1000_0010,
              12'b1000_0000_0010};
    start();
    run = 1; is_alur = 1; mem_ack = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_vec++;
      if (obs !== exp_t[k]) begin
        n_err++; $display("FAIL halt_c%0d: got %b expected %b", k + 1, obs, exp_t[k]);
      end
      if (k == 3) halt_req = 1;
      if (k == 4) begin
        n_vec++;
        if (instr_cnt !== 32'd1) begin
          n_err++; $display("FAIL halt_instr_cnt: got %0d expected 1", instr_cnt);
        end
      end
      if (k == 5) halt_req = 0;
      if (k == 6) begin
        is_alur = 0; is_load = 1;
      end
      if (k == 8) mem_ack = 0;
    end
    rst = 1;
    #1;
    n_vec++;
    if ({obs, err_timeout, instr_cnt} !== 45'd0) begin
      n_err++; $display("FAIL mid_mem_reset: got %b/%0d expected all zero", {obs, err_timeout}, instr_cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_branch();
    test_precedence_nop();
    test_timeout();
    test_halt_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
